// File: rtl/winbuf_pkg.sv
// Shared constants and types for the five-tap window buffer and its downstream adder.
package winbuf_pkg;

   localparam int unsigned WIN_DEPTH   = 5;
   localparam int unsigned ADDER_IN_W  = 37;
   localparam int unsigned ADDER_OUT_W = ADDER_IN_W + 3;

   typedef logic [2:0] fill_cnt_t;
   typedef logic [2:0] stride_cnt_t;

   localparam fill_cnt_t FILL_FULL = fill_cnt_t'(WIN_DEPTH);
   localparam fill_cnt_t FILL_LAST = fill_cnt_t'(WIN_DEPTH - 1);

endpackage

// File: rtl/winbuf_stride_ctr.sv
// Stride counter: produces the registered window strobe once the window is full.
module winbuf_stride_ctr
   import winbuf_pkg::*;
#(
   parameter int STRIDE = 1
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      clr,
   input  logic      accept,
   input  fill_cnt_t fill_q,
   output logic      strobe
);

   localparam stride_cnt_t CNT_LAST = stride_cnt_t'(STRIDE - 1);

   stride_cnt_t cnt_q, cnt_d;
   logic        strobe_q, strobe_d;

   always_comb begin
      cnt_d    = cnt_q;
      strobe_d = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (accept) begin
         if (fill_q == FILL_LAST) begin
            cnt_d    = '0;
            strobe_d = 1'b1;
         end else if (fill_q == FILL_FULL) begin
            if (cnt_q == CNT_LAST) begin
               cnt_d    = '0;
               strobe_d = 1'b1;
            end else begin
               cnt_d = cnt_q + stride_cnt_t'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         strobe_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         strobe_q <= strobe_d;
      end
   end

   assign strobe = strobe_q;

endmodule

// File: rtl/window_buf5.sv
// Five-tap sliding sample window feeding a 5-input adder; dout1 newest, dout5 oldest.
// Optional synchronous flush port enabled by defining WINBUF_FLUSH_EN.
module window_buf5
   import winbuf_pkg::*;
#(
   parameter int input_width = ADDER_IN_W,
   parameter int STRIDE      = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [input_width-1:0] din,
   input  logic                   data_valid,
`ifdef WINBUF_FLUSH_EN
   input  logic                   flush,
`endif
   output logic [input_width-1:0] dout1,
   output logic [input_width-1:0] dout2,
   output logic [input_width-1:0] dout3,
   output logic [input_width-1:0] dout4,
   output logic [input_width-1:0] dout5,
   output logic                   win_valid,
   output logic                   win_strobe,
   output logic [2:0]             fill_cnt
);

   if (STRIDE < 1 || STRIDE > 5) begin : g_bad_stride
      $error("window_buf5: STRIDE must be within 1..5");
   end

   logic flush_w;
`ifdef WINBUF_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   logic [input_width-1:0] tap_q [WIN_DEPTH];
   logic [input_width-1:0] tap_d [WIN_DEPTH];
   fill_cnt_t              fill_q, fill_d;
   logic                   win_valid_q, win_valid_d;
   logic                   accept;

   // Flush outranks data_valid, so a colliding sample never enters the window.
   assign accept = data_valid && !flush_w;

   always_comb begin
      tap_d  = tap_q;
      fill_d = fill_q;
      if (flush_w) begin
         for (int unsigned i = 0; i < WIN_DEPTH; i++) tap_d[i] = '0;
         fill_d = '0;
      end else if (data_valid) begin
         for (int unsigned i = WIN_DEPTH - 1; i > 0; i--) tap_d[i] = tap_q[i-1];
         tap_d[0] = din;
         if (fill_q != FILL_FULL) fill_d = fill_q + fill_cnt_t'(1);
      end
      win_valid_d = (fill_d == FILL_FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < WIN_DEPTH; i++) tap_q[i] <= '0;
         fill_q      <= '0;
         win_valid_q <= 1'b0;
      end else begin
         tap_q       <= tap_d;
         fill_q      <= fill_d;
         win_valid_q <= win_valid_d;
      end
   end

   winbuf_stride_ctr #(
      .STRIDE (STRIDE)
   ) u_stride_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (flush_w),
      .accept (accept),
      .fill_q (fill_q),
      .strobe (win_strobe)
   );

   assign dout1     = tap_q[0];
   assign dout2     = tap_q[1];
   assign dout3     = tap_q[2];
   assign dout4     = tap_q[3];
   assign dout5     = tap_q[4];
   assign win_valid = win_valid_q;
   assign fill_cnt  = fill_q;

endmodule
